// File: rtl/connect4_turn_controller.sv
`default_nettype none
// ============================================================================
// Module      : connect4_turn_controller
// Description : Turn sequencer and board store for a two-player Connect-4
//               game. Accepts column moves from a requester, drops the piece
//               into the lowest free row, then spends one CHECK cycle
//               sampling an external win checker before handing the turn
//               over or ending the game (win or full-board draw).
//
// Ports:
//   clk            rising-edge clock for all state
//   reset_n        asynchronous active-low reset
//   start          new-game request (honoured in IDLE / GAME_OVER only)
//   move_valid     requester presents a move
//   move_col       selected column, 0..NUM_COLS-1
//   win_detected   external checker flag, sampled at the end of CHECK
//   move_ready     controller accepts moves this cycle
//   move_accept    one-cycle pulse: the move was placed
//   move_reject    one-cycle pulse: column full or out of range
//   gameboard      cell occupancy, index = col + row*NUM_COLS, row 0 = bottom
//   players_cells  owner of each occupied cell, 0 = P1, 1 = P2
//   last_cell      index of the most recently placed cell
//   current_player side to move, 0 = P1, 1 = P2
//   state          IDLE=0, P1_TURN=1, P2_TURN=2, CHECK=3, GAME_OVER=4
//   winner         00 none, 01 P1, 10 P2, 11 draw
//
// Revision    : 1.0 - initial release
// ============================================================================
module connect4_turn_controller #(
    parameter int NUM_COLS = 7,
    parameter int NUM_ROWS = 6
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         move_valid,
    input  logic [2:0]                   move_col,
    input  logic                         win_detected,
    output logic                         move_ready,
    output logic                         move_accept,
    output logic                         move_reject,
    output logic [NUM_COLS*NUM_ROWS-1:0] gameboard,
    output logic [NUM_COLS*NUM_ROWS-1:0] players_cells,
    output logic [5:0]                   last_cell,
    output logic                         current_player,
    output logic [2:0]                   state,
    output logic [1:0]                   winner
);

    localparam int c_NUM_CELLS = NUM_COLS * NUM_ROWS;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_P1_TURN   = 3'd1,
        S_P2_TURN   = 3'd2,
        S_CHECK     = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic [2:0]                    r_row_cnt [NUM_COLS];
    logic [5:0]                    r_move_cnt;
    logic [c_NUM_CELLS-1:0]        r_gameboard;
    logic [c_NUM_CELLS-1:0]        r_players;
    logic [5:0]                    r_last_cell;
    logic                          r_player;
    logic [1:0]                    r_winner;
    logic                          r_accept;
    logic                          r_reject;

    logic [2:0]                    w_row;
    logic                          w_col_ok;
    logic                          w_legal;
    logic                          w_present;
    logic                          w_take;
    logic                          w_bad;
    logic                          w_board_full;
    logic                          w_new_game;
    int                            w_idx_full;
    logic [5:0]                    w_idx;

    assign move_ready = (r_state == S_P1_TURN) || (r_state == S_P2_TURN);
    assign w_present  = move_valid && move_ready;

    // Select the fill level of the requested column; an out-of-range column
    // matches no counter and leaves w_col_ok low so it is rejected.
    always_comb begin
        w_row    = '0;
        w_col_ok = 1'b0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (move_col == c[2:0]) begin
                w_row    = r_row_cnt[c];
                w_col_ok = 1'b1;
            end
        end
    end

    assign w_legal      = w_col_ok && (w_row < 3'(NUM_ROWS));
    assign w_take       = w_present && w_legal;
    assign w_bad        = w_present && !w_legal;
    assign w_idx_full   = int'(move_col) + int'(w_row) * NUM_COLS;
    assign w_idx        = w_idx_full[5:0];
    assign w_board_full = (r_move_cnt == 6'(c_NUM_CELLS));
    assign w_new_game   = start && ((r_state == S_IDLE) || (r_state == S_GAME_OVER));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_GAME_OVER: begin
                if (start) w_state_next = S_P1_TURN;
            end
            S_P1_TURN, S_P2_TURN: begin
                if (w_take) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                // A win outranks the draw on the final move.
                if (win_detected || w_board_full) begin
                    w_state_next = S_GAME_OVER;
                end else if (r_player) begin
                    w_state_next = S_P1_TURN;
                end else begin
                    w_state_next = S_P2_TURN;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Board, counters, result and handshake pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_COLS; c++) r_row_cnt[c] <= '0;
            r_move_cnt  <= '0;
            r_gameboard <= '0;
            r_players   <= '0;
            r_last_cell <= '0;
            r_player    <= 1'b0;
            r_winner    <= 2'b00;
            r_accept    <= 1'b0;
            r_reject    <= 1'b0;
        end else begin
            r_accept <= w_take;
            r_reject <= w_bad;

            if (w_new_game) begin
                for (int c = 0; c < NUM_COLS; c++) r_row_cnt[c] <= '0;
                r_move_cnt  <= '0;
                r_gameboard <= '0;
                r_players   <= '0;
                r_last_cell <= '0;
                r_player    <= 1'b0;
                r_winner    <= 2'b00;
            end

            if (w_take) begin
                r_gameboard[w_idx] <= 1'b1;
                r_players[w_idx]   <= r_player;
                r_last_cell        <= w_idx;
                r_move_cnt         <= r_move_cnt + 6'd1;
                for (int c = 0; c < NUM_COLS; c++) begin
                    if (move_col == c[2:0]) r_row_cnt[c] <= r_row_cnt[c] + 3'd1;
                end
            end

            if (r_state == S_CHECK) begin
                if (win_detected) begin
                    r_winner <= r_player ? 2'b10 : 2'b01;
                end else if (w_board_full) begin
                    r_winner <= 2'b11;
                end else begin
                    r_player <= ~r_player;
                end
            end
        end
    end

    assign move_accept    = r_accept;
    assign move_reject    = r_reject;
    assign gameboard      = r_gameboard;
    assign players_cells  = r_players;
    assign last_cell      = r_last_cell;
    assign current_player = r_player;
    assign state          = r_state;
    assign winner         = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_connect4_turn_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_connect4_turn_controller
// Description : Directed self-checking bench for connect4_turn_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_connect4_turn_controller;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        move_valid;
    logic [2:0]  move_col;
    logic        win_detected;
    logic        move_ready;
    logic        move_accept;
    logic        move_reject;
    logic [41:0] gameboard;
    logic [41:0] players_cells;
    logic [5:0]  last_cell;
    logic        current_player;
    logic [2:0]  state;
    logic [1:0]  winner;

    int checks   = 0;
    int failures = 0;

    // Reference game model
    int          m_rows [7];
    int          m_cnt;
    logic [41:0] m_board;
    logic [41:0] m_players;
    logic [5:0]  m_last;
    logic        m_player;
    logic [2:0]  m_state;
    logic [1:0]  m_winner;

    connect4_turn_controller #(
        .NUM_COLS(7),
        .NUM_ROWS(6)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .move_valid     (move_valid),
        .move_col       (move_col),
        .win_detected   (win_detected),
        .move_ready     (move_ready),
        .move_accept    (move_accept),
        .move_reject    (move_reject),
        .gameboard      (gameboard),
        .players_cells  (players_cells),
        .last_cell      (last_cell),
        .current_player (current_player),
        .state          (state),
        .winner         (winner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 7; c++) m_rows[c] = 0;
        m_cnt     = 0;
        m_board   = '0;
        m_players = '0;
        m_last    = '0;
        m_player  = 1'b0;
        m_winner  = 2'b00;
    endtask

    task automatic chk_board(input string tag);
        chk({tag, "_board"},   64'(gameboard),      64'(m_board));
        chk({tag, "_players"}, 64'(players_cells),  64'(m_players));
        chk({tag, "_state"},   64'(state),          64'(m_state));
        chk({tag, "_player"},  64'(current_player), 64'(m_player));
        chk({tag, "_winner"},  64'(winner),         64'(m_winner));
    endtask

    // Present one move, then (if it lands) drive the checker during CHECK.
    task automatic do_move(input int col, input logic win);
        logic legal;
        int   idx;
        legal = 1'b0;
        if (col >= 0 && col < 7) legal = (m_rows[col] < 6);
        move_valid = 1'b1;
        move_col   = col[2:0];
        tick();
        move_valid = 1'b0;
        if (legal) begin
            idx = col + m_rows[col] * 7;
            m_board[idx]   = 1'b1;
            m_players[idx] = m_player;
            m_last         = idx[5:0];
            m_rows[col]++;
            m_cnt++;
            m_state = 3'd3;
            chk("mv_accept", 64'(move_accept), 64'd1);
            chk("mv_reject", 64'(move_reject), 64'd0);
            chk("mv_ready",  64'(move_ready),  64'd0);
            chk("mv_last",   64'(last_cell),   64'(m_last));
            chk_board("mv");
            win_detected = win;
            tick();
            win_detected = 1'b0;
            if (win) begin
                m_state  = 3'd4;
                m_winner = m_player ? 2'b10 : 2'b01;
            end else if (m_cnt == 42) begin
                m_state  = 3'd4;
                m_winner = 2'b11;
            end else begin
                m_player = ~m_player;
                m_state  = m_player ? 3'd2 : 3'd1;
            end
            chk("ck_accept", 64'(move_accept), 64'd0);
            chk("ck_ready",  64'(move_ready),  64'(m_state != 3'd4));
            chk_board("ck");
        end else begin
            chk("rj_reject", 64'(move_reject), 64'd1);
            chk("rj_accept", 64'(move_accept), 64'd0);
            chk_board("rj");
            tick();
            chk("rj_drop", 64'(move_reject), 64'd0);
            chk_board("rj2");
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        move_valid   = 1'b0;
        move_col     = 3'd0;
        win_detected = 1'b0;
        model_clear();
        m_state = 3'd0;

        // Reset state
        tick();
        tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_ready", 64'(move_ready), 64'd0);
        chk("rst_accept", 64'(move_accept), 64'd0);
        chk("rst_reject", 64'(move_reject), 64'd0);
        chk("rst_last", 64'(last_cell), 64'd0);
        chk_board("rst");

        // First edge after release is an ordinary IDLE cycle
        reset_n = 1'b1;
        tick();
        chk("idle_state", 64'(state), 64'd0);

        // move_valid in IDLE is ignored
        move_valid = 1'b1;
        move_col   = 3'd2;
        tick();
        move_valid = 1'b0;
        chk("idle_mv_accept", 64'(move_accept), 64'd0);
        chk("idle_mv_reject", 64'(move_reject), 64'd0);
        chk("idle_mv_board", 64'(gameboard), 64'd0);

        start = 1'b1;
        tick();
        start   = 1'b0;
        m_state = 3'd1;
        chk("start_ready", 64'(move_ready), 64'd1);
        chk_board("start");

        // P1 col 3: hand-computed cell 3, then P2_TURN two cycles later
        do_move(3, 1'b0);
        chk("p1c3_board", 64'(gameboard), 64'h8);
        chk("p1c3_players", 64'(players_cells), 64'h0);
        chk("p1c3_last", 64'(last_cell), 64'd3);
        chk("p1c3_state", 64'(state), 64'd2);

        // start during a turn is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_board("start_ign");

        // Fill column 0, then overflow it
        for (int i = 0; i < 6; i++) do_move(0, 1'b0);
        chk("col0_full_last", 64'(last_cell), 64'd35);
        do_move(0, 1'b0);
        chk("col0_rej_player", 64'(current_player), 64'd1);
        do_move(1, 1'b0);

        // Out-of-range column
        do_move(7, 1'b0);
        chk("col7_state", 64'(state), 64'd1);

        // P1 plays, then P2 wins
        do_move(2, 1'b0);
        do_move(4, 1'b1);
        chk("win_state", 64'(state), 64'd4);
        chk("win_winner", 64'(winner), 64'b10);

        // Moves ignored in GAME_OVER
        move_valid = 1'b1;
        move_col   = 3'd5;
        tick();
        tick();
        move_valid = 1'b0;
        chk("go_accept", 64'(move_accept), 64'd0);
        chk("go_reject", 64'(move_reject), 64'd0);
        chk_board("go_hold");

        // Restart clears the board
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
        m_state = 3'd1;
        chk("restart_board", 64'(gameboard), 64'd0);
        chk("restart_last", 64'(last_cell), 64'd0);
        chk_board("restart");

        // Full-board draw
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++) do_move(c, 1'b0);
        chk("draw_winner", 64'(winner), 64'b11);
        chk("draw_board", 64'(gameboard), 64'h3FF_FFFF_FFFF);
        chk("draw_state", 64'(state), 64'd4);

        // Same fill, win on the final CHECK: last mover (P2) wins
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
        m_state = 3'd1;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++) do_move(c, (c == 6 && r == 5));
        chk("lastwin_winner", 64'(winner), 64'b10);

        // Reset asserted during CHECK takes effect immediately
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
        m_state = 3'd1;
        move_valid = 1'b1;
        move_col   = 3'd6;
        tick();
        move_valid = 1'b0;
        chk("pre_rst_state", 64'(state), 64'd3);
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        m_state = 3'd0;
        chk("async_state", 64'(state), 64'd0);
        chk("async_accept", 64'(move_accept), 64'd0);
        chk("async_last", 64'(last_cell), 64'd0);
        chk_board("async");
        start = 1'b1;
        tick();
        chk("rst_start_ign", 64'(state), 64'd0);
        start   = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("post_rst_idle", 64'(state), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_start", 64'(state), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/connect4_turn_controller.md
CONNECT4_TURN_CONTROLLER -- requirements
Module: connect4_turn_controller

Interface
REQ-001 The block SHALL have the parameter NUM_COLS, default 7, meaning the number of board columns.
REQ-002 The block SHALL have the parameter NUM_ROWS, default 6, meaning the number of board rows; the board size is NUM_COLS*NUM_ROWS = 42 cells.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have the port clk  input  1  rising-edge clock for all state.
REQ-005 The block SHALL have the port reset_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have the port start  input  1  new-game request.
REQ-007 The block SHALL have the port move_valid  input  1  requester presents a move.
REQ-008 The block SHALL have the port move_col  input  3  selected column, 0..6.
REQ-009 The block SHALL have the port win_detected  input  1  external checker flag, valid while in CHECK.
REQ-010 The block SHALL have the port move_ready  output  1  controller accepts moves this cycle.
REQ-011 The block SHALL have the port move_accept  output  1  one-cycle pulse: the move was placed.
REQ-012 The block SHALL have the port move_reject  output  1  one-cycle pulse: the column was full or out of range.
REQ-013 The block SHALL have the port gameboard  output  42  cell occupancy, 1 = occupied; index = col + row*7, row 0 = bottom.
REQ-014 The block SHALL have the port players_cells  output  42  owner of each occupied cell, 0 = P1, 1 = P2.
REQ-015 The block SHALL have the port last_cell  output  6  index of the most recently placed cell.
REQ-016 The block SHALL have the port current_player  output  1  side to move, 0 = P1, 1 = P2.
REQ-017 The block SHALL have the port state  output  3  FSM encoding: IDLE=0, P1_TURN=1, P2_TURN=2, CHECK=3, GAME_OVER=4.
REQ-018 The block SHALL have the port winner  output  2  game result: 00 = none, 01 = P1, 10 = P2, 11 = draw.

Function
REQ-019 The block SHALL keep seven 3-bit row counters (one per column) and a 6-bit move counter.
REQ-020 In IDLE or GAME_OVER, start=1 SHALL clear gameboard, players_cells, last_cell, winner, all row counters and the move counter, and SHALL enter P1_TURN with current_player=0.
REQ-021 In P1_TURN, P2_TURN and CHECK, start SHALL be ignored.
REQ-022 move_ready SHALL equal 1 exactly when state is P1_TURN or P2_TURN.
REQ-023 A move is presented when move_valid=1 and move_ready=1 at a rising edge.
REQ-024 A presented move SHALL be legal if move_col < NUM_COLS and row_count[move_col] < NUM_ROWS.
REQ-025 On a legal move, at the same edge, the block SHALL:
- set gameboard[idx]=1, where idx = move_col + row_count[move_col]*7;
- set players_cells[idx] = current_player and last_cell = idx;
- increment row_count[move_col] and the move counter;
- enter CHECK.
REQ-026 move_accept SHALL be high for exactly the one cycle following a legal move, which is the CHECK cycle.
REQ-027 On an illegal move, the board and counters SHALL remain unchanged, move_reject SHALL pulse for one cycle, and the state SHALL stay in the same turn.
REQ-028 CHECK SHALL last exactly one cycle and SHALL sample win_detected at its closing edge:
- win_detected=1: enter GAME_OVER, winner = current_player+1;
- else, move counter = 42: enter GAME_OVER, winner = 11;
- else: toggle current_player and enter the corresponding turn state.
REQ-029 win_detected SHALL take priority over draw when both hold on the 42nd move.
REQ-030 move_valid outside a turn state SHALL be ignored with no pulse.
REQ-031 Latency from one accepted move to the next move_ready=1 SHALL be 2 cycles.
REQ-032 In GAME_OVER, the board and winner SHALL hold until start or reset.
REQ-033 move_accept and move_reject SHALL never be high in the same cycle.

Reset
REQ-034 When reset_n=0, at any time including mid-game, the block SHALL immediately set:
- state=IDLE;
- gameboard, players_cells, last_cell, winner, all counters and current_player to 0;
- move_accept and move_reject to 0.
REQ-035 The first rising edge after reset_n deasserts SHALL be treated as a normal IDLE cycle.

Verification
REQ-036 Reset, start, then P1 col 3 -> gameboard[3]=1, players_cells[3]=0, last_cell=3, move_accept pulse; 2 cycles later state=P2_TURN.
REQ-037 Six alternating moves into col 0, then a seventh into col 0 -> move_reject pulse, board unchanged, same player to move; then col 1 is accepted.
REQ-038 move_col=7 -> move_reject pulse, no board change.
REQ-039 win_detected=1 during the CHECK after P2's move -> state=GAME_OVER, winner=10; later move_valid is ignored; start clears the board to 0 and enters P1_TURN.
REQ-040 A 42-move fill with no win -> winner=11 and gameboard=all ones; the same fill with win_detected on the last CHECK -> winner reflects the last mover.
REQ-041 reset_n pulled low during CHECK -> outputs are zero immediately; start is ignored while reset_n=0.
